mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and two-way arbiter for the single shared memory port of the multi-cycle CPU. It serialises requests from two sources onto one synchronous RAM port: instruction fetch and data access driven by the main control unit (`MemRd`/`MemWr`/`IorD` path), and a debug/loader port. It stalls the CPU while its access is pending, and returns read data through a holding register.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1: read latency of the RAM in cycles after the `mem_en` cycle. Legal range is 1–15.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `cpu_rd`  in  1: CPU read request, level, held while `cpu_stall` is high.
- `cpu_wr`  in  1: CPU write request, level.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_rdata`  out  DATA_W: read data; valid in the CPU's completion cycle.
- `cpu_stall`  out  1: freeze CPU state (PC, IR, FSM) this cycle.
- `dbg_req`  in  1: debug request, held until `dbg_ack`.
- `dbg_we`  in  1: debug write (1) or read (0).
- `dbg_addr`  in  ADDR_W: debug address.
- `dbg_wdata`  in  DATA_W: debug write data.
- `dbg_rdata`  out  DATA_W: debug read data; valid with `dbg_ack`.
- `dbg_ack`  out  1: one-cycle completion pulse.
- `mem_en`  out  1: RAM access strobe, one cycle per transaction.
- `mem_we`  out  1: RAM write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  DATA_W: RAM write data.
- `mem_rdata`  in  DATA_W: RAM read data, valid `MEM_LAT` cycles after the `mem_en` cycle.

## Operation

- **FSM states**: IDLE, ISSUE, WAIT, RESP.
- **IDLE**:
  - The CPU requests when `cpu_rd|cpu_wr` is high; debug requests when `dbg_req` is high.
  - If exactly one source requests, it is the owner.
  - If both request, the owner is the source that is not `last_owner`.
  - On the edge: latch owner, address, write flag and wdata into registers, then go to ISSUE.
  - If `cpu_rd` and `cpu_wr` are both high, the access is treated as a write.
- **ISSUE**:
  - `mem_en=1`; `mem_we`, `mem_addr` and `mem_wdata` come from the latched registers.
  - Load the counter with `MEM_LAT-1`, then go to WAIT.
- **WAIT**:
  - `mem_en=0`. While the counter is non-zero, decrement it.
  - When the counter is 0, capture `mem_rdata` into `rdata_q` (also captured for writes; the value is don't-care) and go to RESP.
- **RESP**:
  - If the owner is the CPU: `cpu_stall=0`. If the owner is debug: `dbg_ack=1`.
  - `last_owner <= owner`; go to IDLE.
- **Outputs**:
  - `cpu_rdata = dbg_rdata = rdata_q`. The register holds its value until the next capture.
  - `cpu_stall = (cpu_rd|cpu_wr) & ~(state==RESP & owner==CPU)`. This is combinational, so a CPU request stalls in the same cycle it is raised.
  - `mem_addr`, `mem_wdata` and `mem_we` hold the latched values outside ISSUE. Only `mem_en` qualifies them.
- **Request retraction**:
  - The request is sampled only in IDLE.
  - A request dropped after latching does not abort the transaction; it completes and acks normally.
  - A request dropped before latching is never serviced.
- **Reset** (`rst_n=0` at an edge), including mid-transaction:
  - state=IDLE, `mem_en=0`, `dbg_ack=0`, `rdata_q=0`, counter=0, `last_owner`=DBG (so the CPU wins the first conflict), latched address/data=0.
  - An in-flight transaction is discarded without ack.
  - `cpu_stall` follows its equation, so it is high during reset if the CPU is requesting.

## Timing

- A request first seen in IDLE at cycle t gives ISSUE at t+1, WAIT t+2..t+1+MEM_LAT, RESP at t+2+MEM_LAT.
- Completion latency is MEM_LAT+2 cycles. The CPU is stalled for MEM_LAT+2 cycles and proceeds in the RESP cycle.
- After RESP the FSM is always in IDLE for one cycle. Peak throughput is one transaction per MEM_LAT+3 cycles.
- There is exactly one `mem_en` pulse per transaction and at most one transaction in flight.
- `dbg_ack` is never high for two consecutive cycles.
- Under continuous requests from both sources, grants strictly alternate CPU, DBG, CPU, …

## Test plan

- **Reset**: hold `rst_n=0` 3 cycles with no requests, then release → `mem_en=0`, `dbg_ack=0`, `cpu_stall=0`, `cpu_rdata=0`.
- **CPU read, MEM_LAT=1**: RAM[0x40]=0xDEADBEEF; raise `cpu_rd` with `cpu_addr=0x40` at t0 → `mem_en` at t0+1 with addr 0x40 and `mem_we=0`; `cpu_stall` high t0..t0+2, low at t0+3; `cpu_rdata=0xDEADBEEF` at t0+3.
- **Debug write then CPU read**: `dbg_req`, `dbg_we=1`, addr 0x80, data 0x12345678 → `dbg_ack` 3 cycles later. A subsequent `cpu_rd` of 0x80 returns 0x12345678.
- **Simultaneous requests after reset**: CPU read 0x10 and debug read 0x20 both raised at t0 → CPU served first (`mem_en` at t0+1 with addr 0x10); debug `mem_en` at t0+5 with addr 0x20; `dbg_ack` at t0+7. Holding both continuously, the `mem_en` address sequence is 0x10, 0x20, 0x10, 0x20.
- **Reset mid-operation**: assert `rst_n=0` during WAIT of a debug read → no `dbg_ack` ever. After release, a pending CPU request is granted first.
- **MEM_LAT=4**: CPU read → `mem_en` once; `cpu_stall` high for 6 cycles; data sampled in the 4th WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Sequencer and two-way arbiter for the shared memory port of the multi-cycle CPU.
// Serialises CPU and debug accesses onto one synchronous RAM port, stalls the CPU
// while its access is pending, and returns read data through a holding register.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1   // legal 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU side
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // Debug / loader side
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  // RAM port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic       OwnCpu  = 1'b0;
  localparam logic       OwnDbg  = 1'b1;
  localparam logic [3:0] LatLoad = 4'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cpu_req;

  assign cpu_req = cpu_rd | cpu_wr;

  // Next-state logic: arbitration in idle, latency countdown, read-data capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || dbg_req) begin
          // On conflict the source that did not win last time gets the port.
          if (cpu_req && dbg_req) owner_d = ~last_owner_q;
          else                    owner_d = dbg_req ? OwnDbg : OwnCpu;
          if (owner_d == OwnDbg) begin
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
            we_d    = dbg_we;
          end else begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            we_d    = cpu_wr;  // rd and wr together counts as a write
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = LatLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = mem_rdata;  // captured for writes too; value unused then
          state_d = StResp;
        end
      end
      StResp: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset; last owner resets to debug
  // so the CPU wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      last_owner_q <= OwnDbg;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decoded from state; RAM address/data hold the latched values throughout.
  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_rdata = rdata_q;
    dbg_rdata = rdata_q;
    dbg_ack   = (state_q == StResp) && (owner_q == OwnDbg);
    // Combinational so a fresh CPU request stalls in the cycle it is raised.
    cpu_stall = cpu_req && !((state_q == StResp) && (owner_q == OwnCpu));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=4,
// each backed by a small RAM model that returns a poison word outside the valid cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_rd, cpu_wr, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we;

  logic [31:0] cpu_rdata_4, dbg_rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
  logic        cpu_stall_4, dbg_ack_4, mem_en_4, mem_we_4;

  logic [31:0] ram1 [256];
  logic [31:0] ram4 [256];
  logic [31:0] pipe4 [4];

  int errors;
  int checks;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_4), .cpu_stall(cpu_stall_4),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata_4), .dbg_ack(dbg_ack_4),
    .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
    .mem_rdata(mem_rdata_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_init(int i);
    case (i)
      'h40:    return 32'hDEADBEEF;
      'h10:    return 32'h11110010;
      'h20:    return 32'h22220020;
      default: return {24'hC0FFEE, 8'(i)};
    endcase
  endfunction

  assign mem_rdata_4 = pipe4[3];

  // RAM models: data valid exactly MEM_LAT cycles after the mem_en cycle, poison otherwise.
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram1[i] = ram_init(i);
      ram4[i] = ram_init(i);
    end
    mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) pipe4[i] = 32'h0;
    forever begin
      @(posedge clk);
      mem_rdata <= mem_en ? ram1[mem_addr[7:0]] : 32'hBAD00001;
      if (mem_en && mem_we) ram1[mem_addr[7:0]] = mem_wdata;
      pipe4[0] <= mem_en_4 ? ram4[mem_addr_4[7:0]] : 32'hBAD00004;
      pipe4[1] <= pipe4[0];
      pipe4[2] <= pipe4[1];
      pipe4[3] <= pipe4[2];
      if (mem_en_4 && mem_we_4) ram4[mem_addr_4[7:0]] = mem_wdata_4;
    end
  end

  // Leaves the bench at a negedge in an idle cycle with reset released.
  task automatic do_reset();
    @(negedge clk);
    cpu_rd = 0; cpu_wr = 0; dbg_req = 0; dbg_we = 0;
    cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_rd = 0; cpu_wr = 0; dbg_req = 0; dbg_we = 0;
    cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL reset_dbg_ack: got %b want 0", dbg_ack); end
    checks++; if (cpu_stall !== 1'b0) begin errors++;
      $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    checks++; if (cpu_rdata_4 !== 32'h0) begin errors++;
      $display("FAIL reset_cpu_rdata_4: got %h want 0", cpu_rdata_4); end
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL reset_idle_mem_en: got %b want 0", mem_en); end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_rd = 1; cpu_addr = 32'h40;  // t0
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++;
      $display("FAIL rd_stall_t0: got %b want 1", cpu_stall); end
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL rd_en_t0: got %b want 0", mem_en); end
    @(negedge clk);  // t0+1
    checks++; if (mem_en !== 1'b1) begin errors++;
      $display("FAIL rd_en_t1: got %b want 1", mem_en); end
    checks++; if (mem_addr !== 32'h40) begin errors++;
      $display("FAIL rd_addr_t1: got %h want 40", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++;
      $display("FAIL rd_we_t1: got %b want 0", mem_we); end
    checks++; if (cpu_stall !== 1'b1) begin errors++;
      $display("FAIL rd_stall_t1: got %b want 1", cpu_stall); end
    @(negedge clk);  // t0+2
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL rd_en_t2: got %b want 0", mem_en); end
    checks++; if (mem_addr !== 32'h40) begin errors++;
      $display("FAIL rd_addr_hold_t2: got %h want 40", mem_addr); end
    checks++; if (cpu_stall !== 1'b1) begin errors++;
      $display("FAIL rd_stall_t2: got %b want 1", cpu_stall); end
    @(negedge clk);  // t0+3
    checks++; if (cpu_stall !== 1'b0) begin errors++;
      $display("FAIL rd_stall_t3: got %b want 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_data_t3: got %h want deadbeef", cpu_rdata); end
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL rd_no_dbg_ack: got %b want 0", dbg_ack); end
    cpu_rd = 0;
    @(negedge clk);  // t0+4
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL rd_en_t4: got %b want 0", mem_en); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_data_hold: got %h want deadbeef", cpu_rdata); end
  endtask

  task automatic test_dbg_write_cpu_read();
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'h12345678;
    @(negedge clk);  // t0+1
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++;
      $display("FAIL dw_issue: got en=%b we=%b want en=1 we=1", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h80 || mem_wdata !== 32'h12345678) begin errors++;
      $display("FAIL dw_addr_data: got %h/%h want 80/12345678", mem_addr, mem_wdata); end
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL dw_ack_t1: got %b want 0", dbg_ack); end
    @(negedge clk);  // t0+2
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL dw_ack_t2: got %b want 0", dbg_ack); end
    @(negedge clk);  // t0+3
    checks++; if (dbg_ack !== 1'b1) begin errors++;
      $display("FAIL dw_ack_t3: got %b want 1", dbg_ack); end
    dbg_req = 0; dbg_we = 0;
    @(negedge clk);  // t0+4, idle
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL dw_ack_t4: got %b want 0", dbg_ack); end
    cpu_rd = 1; cpu_addr = 32'h80;
    repeat (3) @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++;
      $display("FAIL dw_rd_stall: got %b want 0", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h12345678) begin errors++;
      $display("FAIL dw_rd_data: got %h want 12345678", cpu_rdata); end
    cpu_rd = 0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_addr;
    do_reset();
    cpu_rd = 1; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++; if (mem_en !== (c % 4 == 1)) begin errors++;
        $display("FAIL sim_en_c%0d: got %b want %b", c, mem_en, (c % 4 == 1)); end
      if (c % 4 == 1) begin
        exp_addr = ((c / 4) % 2 == 0) ? 32'h10 : 32'h20;
        checks++; if (mem_addr !== exp_addr) begin errors++;
          $display("FAIL sim_addr_c%0d: got %h want %h", c, mem_addr, exp_addr); end
      end
      checks++; if (dbg_ack !== (c % 8 == 7)) begin errors++;
        $display("FAIL sim_ack_c%0d: got %b want %b", c, dbg_ack, (c % 8 == 7)); end
      checks++; if (cpu_stall !== (c % 8 != 3)) begin errors++;
        $display("FAIL sim_stall_c%0d: got %b want %b", c, cpu_stall, (c % 8 != 3)); end
      if (c == 3) begin
        checks++; if (cpu_rdata !== 32'h11110010) begin errors++;
          $display("FAIL sim_cpu_data: got %h want 11110010", cpu_rdata); end
      end
      if (c == 7) begin
        checks++; if (dbg_rdata !== 32'h22220020) begin errors++;
          $display("FAIL sim_dbg_data: got %h want 22220020", dbg_rdata); end
      end
    end
    cpu_rd = 0; dbg_req = 0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL sim_drain: got %b want 0", mem_en); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu_rd = 1; cpu_addr = 32'h10;  // makes the CPU the last owner
    repeat (3) @(negedge clk);
    cpu_rd = 0;
    @(negedge clk);  // idle
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    @(negedge clk);  // debug issue
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin errors++;
      $display("FAIL rm_dbg_issue: got en=%b addr=%h want en=1 addr=20", mem_en, mem_addr); end
    @(negedge clk);  // debug wait
    rst_n = 0; cpu_rd = 1; cpu_addr = 32'h10;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++;
      $display("FAIL rm_stall_in_reset: got %b want 1", cpu_stall); end
    @(negedge clk);
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL rm_ack_r1: got %b want 0", dbg_ack); end
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL rm_en_r1: got %b want 0", mem_en); end
    @(negedge clk);
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL rm_ack_r2: got %b want 0", dbg_ack); end
    rst_n = 1;  // both requesting in this idle cycle
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin errors++;
      $display("FAIL rm_cpu_first: got en=%b addr=%h want en=1 addr=10", mem_en, mem_addr); end
    @(negedge clk);
    checks++; if (dbg_ack !== 1'b0) begin errors++;
      $display("FAIL rm_ack_w: got %b want 0", dbg_ack); end
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin errors++;
      $display("FAIL rm_cpu_resp: got stall=%b ack=%b want 0/0", cpu_stall, dbg_ack); end
    cpu_rd = 0;
    repeat (4) @(negedge clk);
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h22220020) begin errors++;
      $display("FAIL rm_dbg_later: got ack=%b data=%h want 1/22220020", dbg_ack, dbg_rdata); end
    dbg_req = 0;
    @(negedge clk);
  endtask

  task automatic test_lat4();
    do_reset();
    cpu_rd = 1; cpu_addr = 32'h40;
    #1;
    checks++; if (cpu_stall_4 !== 1'b1) begin errors++;
      $display("FAIL l4_stall_c0: got %b want 1", cpu_stall_4); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (mem_en_4 !== (c == 1)) begin errors++;
        $display("FAIL l4_en_c%0d: got %b want %b", c, mem_en_4, (c == 1)); end
      checks++; if (cpu_stall_4 !== (c < 6)) begin errors++;
        $display("FAIL l4_stall_c%0d: got %b want %b", c, cpu_stall_4, (c < 6)); end
    end
    checks++; if (cpu_rdata_4 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL l4_data: got %h want deadbeef", cpu_rdata_4); end
    cpu_rd = 0;
    @(negedge clk);
    checks++; if (mem_en_4 !== 1'b0) begin errors++;
      $display("FAIL l4_en_after: got %b want 0", mem_en_4); end
  endtask

  task automatic test_rd_wr_both();
    do_reset();
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++;
      $display("FAIL rw_issue: got en=%b we=%b want 1/1", mem_en, mem_we); end
    checks++; if (mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h30) begin errors++;
      $display("FAIL rw_data: got %h/%h want 30/a5a5a5a5", mem_addr, mem_wdata); end
    repeat (2) @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++;
      $display("FAIL rw_stall: got %b want 0", cpu_stall); end
    cpu_rd = 0; cpu_wr = 0;
    @(negedge clk);
    cpu_rd = 1; cpu_addr = 32'h30;
    repeat (3) @(negedge clk);
    checks++; if (cpu_rdata !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL rw_readback: got %h want a5a5a5a5", cpu_rdata); end
    cpu_rd = 0;
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 0;
    cpu_rd = 0; cpu_wr = 0; dbg_req = 0; dbg_we = 0;
    cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
    test_reset();
    test_cpu_read();
    test_dbg_write_cpu_read();
    test_simultaneous();
    test_reset_mid();
    test_lat4();
    test_rd_wr_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
